// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: registered MIPS ALU control plus iterative mul/div sequencer owning HI/LO.
// Optional macro SIGNED_MD_EN adds signed MULT/DIV with a sign-fix state.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Valid,
    output logic             Ready,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [3:0]       ALUCtrl,
    output logic             CtrlValid,
    output logic             Busy,
    output logic             MdDone,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

`ifdef SIGNED_MD_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
`endif

    state_t           state;
    state_t           after_iter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ph, pl, opb;
    logic [3:0]       dec;
    logic             start_mul, start_div, accept, last;
    logic [WIDTH-1:0] opa_in, opb_in;
    logic [WIDTH:0]   sum, sh;
    logic [WIDTH-1:0] dsub;
    logic             ge;
    logic [WIDTH-1:0] mul_ph, mul_pl, div_ph, div_pl;
`ifdef SIGNED_MD_EN
    logic             start_sgn;
    logic             sgn_op, is_div, neg_q, neg_r;
`endif

    assign Ready  = ~Busy;
    assign accept = Valid & Ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Combinational decode of ALUOp/Funct into op code and sequencer start
    always_comb begin
        dec       = 4'b1111;
        start_mul = 1'b0;
        start_div = 1'b0;
`ifdef SIGNED_MD_EN
        start_sgn = 1'b0;
`endif
        unique case (ALUOp)
            3'b000: dec = 4'b0010;
            3'b001: dec = 4'b0110;
            3'b010: begin
                unique case (Funct)
                    6'b100100: dec = 4'b0000;
                    6'b100101: dec = 4'b0001;
                    6'b100000: dec = 4'b0010;
                    6'b100010: dec = 4'b0110;
                    6'b101010: dec = 4'b0111;
                    6'b100111: dec = 4'b1100;
                    6'b010000: dec = 4'b1000;
                    6'b010010: dec = 4'b1001;
                    6'b011001: start_mul = 1'b1;
                    6'b011011: start_div = 1'b1;
`ifdef SIGNED_MD_EN
                    6'b011000: begin
                        start_mul = 1'b1;
                        start_sgn = 1'b1;
                    end
                    6'b011010: begin
                        start_div = 1'b1;
                        start_sgn = 1'b1;
                    end
`endif
                    default: dec = 4'b1111;
                endcase
            end
            3'b011: dec = 4'b0010;
            3'b100: dec = 4'b0111;
            3'b101: dec = 4'b1110;
            3'b110: dec = 4'b0001;
            3'b111: dec = 4'b0000;
            default: dec = 4'b1111;
        endcase
    end

    // Operand magnitudes at accept; signed ops are iterated unsigned
`ifdef SIGNED_MD_EN
    assign opa_in     = (start_sgn && A[WIDTH-1]) ? -A : A;
    assign opb_in     = (start_sgn && B[WIDTH-1]) ? -B : B;
    assign after_iter = sgn_op ? S_FIX : S_FIN;
`else
    assign opa_in     = A;
    assign opb_in     = B;
    assign after_iter = S_FIN;
`endif

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        sum    = {1'b0, ph} + (pl[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_ph = sum[WIDTH:1];
        mul_pl = {sum[0], pl[WIDTH-1:1]};
        sh     = {ph, pl[WIDTH-1]};
        ge     = (sh >= {1'b0, opb});
        dsub   = sh[WIDTH-1:0] - opb;
        div_ph = ge ? dsub : sh[WIDTH-1:0];
        div_pl = {pl[WIDTH-2:0], ge};
    end

    // Registered decode output, updated only on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUCtrl   <= 4'b1111;
            CtrlValid <= 1'b0;
        end else begin
            CtrlValid <= accept;
            if (accept) ALUCtrl <= dec;
        end
    end

    // Mul/div sequencer; ph/pl hold the working product or remainder/quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ph     <= '0;
            pl     <= '0;
            opb    <= '0;
            Busy   <= 1'b0;
            MdDone <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
`ifdef SIGNED_MD_EN
            sgn_op <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            MdDone <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept && (start_mul || start_div)) begin
                        cnt  <= '0;
                        opb  <= opb_in;
                        ph   <= '0;
                        pl   <= opa_in;
                        Busy <= 1'b1;
`ifdef SIGNED_MD_EN
                        sgn_op <= start_sgn;
                        is_div <= start_div;
                        neg_q  <= start_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= start_sgn & A[WIDTH-1];
`endif
                        if (start_div && B == '0) begin
                            ph    <= A;
                            pl    <= '1;
                            state <= S_FIN;
                        end else begin
                            state <= start_mul ? S_MUL : S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    ph  <= mul_ph;
                    pl  <= mul_pl;
                    cnt <= cnt + 1'b1;
                    if (last) state <= after_iter;
                end
                S_DIV: begin
                    ph  <= div_ph;
                    pl  <= div_pl;
                    cnt <= cnt + 1'b1;
                    if (last) state <= after_iter;
                end
`ifdef SIGNED_MD_EN
                S_FIX: begin
                    if (is_div) begin
                        if (neg_q) pl <= -pl;
                        if (neg_r) ph <= -ph;
                    end else if (neg_q) begin
                        {ph, pl} <= -{ph, pl};
                    end
                    state <= S_FIN;
                end
`endif
                S_FIN: begin
                    Hi     <= ph;
                    Lo     <= pl;
                    MdDone <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl.
// Expected decode and HI/LO results are queued at issue and checked by a monitor.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Valid = 1'b0;
    logic        Ready;
    logic [2:0]  ALUOp = 3'b000;
    logic [5:0]  Funct = 6'b000000;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  ALUCtrl;
    logic        CtrlValid;
    logic        Busy;
    logic        MdDone;
    logic [31:0] Hi;
    logic [31:0] Lo;

    alu_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Valid(Valid), .Ready(Ready),
        .ALUOp(ALUOp), .Funct(Funct), .A(A), .B(B),
        .ALUCtrl(ALUCtrl), .CtrlValid(CtrlValid), .Busy(Busy),
        .MdDone(MdDone), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } md_t;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] e;
    } vec_t;

    logic [3:0] ctrl_q[$];
    md_t        md_q[$];
    int         errors = 0;
    int         checks = 0;
    int         busy_cnt = 0;
    logic [3:0] exp_c;
    md_t        exp_m;

    vec_t dv [19] = '{
        '{3'b010, 6'b100010, 4'b0110},
        '{3'b010, 6'b111111, 4'b1111},
        '{3'b010, 6'b100100, 4'b0000},
        '{3'b010, 6'b100101, 4'b0001},
        '{3'b010, 6'b100000, 4'b0010},
        '{3'b010, 6'b101010, 4'b0111},
        '{3'b010, 6'b100111, 4'b1100},
        '{3'b010, 6'b010000, 4'b1000},
        '{3'b010, 6'b010010, 4'b1001},
        '{3'b010, 6'b000000, 4'b1111},
        '{3'b000, 6'b100010, 4'b0010},
        '{3'b001, 6'b000000, 4'b0110},
        '{3'b011, 6'b000000, 4'b0010},
        '{3'b100, 6'b000000, 4'b0111},
        '{3'b101, 6'b000000, 4'b1110},
        '{3'b110, 6'b000000, 4'b0001},
        '{3'b111, 6'b000000, 4'b0000},
        '{3'b010, 6'b100101, 4'b0001},
        '{3'b010, 6'b011111, 4'b1111}
    };

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (Busy) busy_cnt++;
            if (CtrlValid) begin
                if (ctrl_q.size() == 0) begin
                    chk("ctrl_unexpected", {63'd0, CtrlValid}, 64'd0);
                end else begin
                    exp_c = ctrl_q.pop_front();
                    chk("alu_ctrl", {60'd0, ALUCtrl}, {60'd0, exp_c});
                end
            end
            if (MdDone) begin
                if (md_q.size() == 0) begin
                    chk("mddone_unexpected", {63'd0, MdDone}, 64'd0);
                end else begin
                    exp_m = md_q.pop_front();
                    chk("md_hi", {32'd0, Hi}, {32'd0, exp_m.hi});
                    chk("md_lo", {32'd0, Lo}, {32'd0, exp_m.lo});
                    chk("busy_cycles", 64'(busy_cnt), 64'(exp_m.busy));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic md_seen);
        int n;
        n = 0;
        @(negedge clk);
        while (!Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!Ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got Ready=%0b expected 1", Ready);
        end
        md_seen = MdDone;
        Valid = 1'b1;
        ALUOp = op;
        Funct = fn;
        A = a;
        B = b;
        @(posedge clk);
        #1 Valid = 1'b0;
    endtask

    task automatic ctrl(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] e);
        logic s;
        ctrl_q.push_back(e);
        issue(op, fn, 32'd0, 32'd0, s);
    endtask

    task automatic md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] h, input logic [31:0] l, input int bc,
                      output logic seen);
        md_t m;
        m.hi = h;
        m.lo = l;
        m.busy = bc;
        ctrl_q.push_back(4'b1111);
        md_q.push_back(m);
        issue(3'b010, fn, a, b, seen);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ctrl_q.size() != 0 || md_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_ctrl_q", 64'(ctrl_q.size()), 64'd0);
        chk("drain_md_q", 64'(md_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst_aluctrl", {60'd0, ALUCtrl}, 64'hF);
        chk("rst_ctrlvalid", {63'd0, CtrlValid}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_mddone", {63'd0, MdDone}, 64'd0);
        chk("rst_hi", {32'd0, Hi}, 64'd0);
        chk("rst_lo", {32'd0, Lo}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) ctrl(dv[i].op, dv[i].fn, dv[i].e);
        drain();

        md(6'b011001, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 33, seen);
        md(6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 33, seen);
        chk("b2b_accept_in_mddone", {63'd0, seen}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Valid = 1'b1;
            ALUOp = 3'b000;
            A = $urandom;
            B = $urandom;
            chk("busy_ready_low", {63'd0, Ready}, 64'd0);
            chk("busy_aluctrl_hold", {60'd0, ALUCtrl}, 64'hF);
        end
        @(negedge clk);
        Valid = 1'b0;
        ctrl_q.push_back(4'b1001);
        issue(3'b010, 6'b010010, 32'd0, 32'd0, seen);
        chk("mflo_in_mddone", {63'd0, seen}, 64'd1);
        chk("mflo_sees_lo", {32'd0, Lo}, 64'd14);
        drain();

        md(6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, seen);
        drain();

`ifdef SIGNED_MD_EN
        md(6'b011010, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, seen);
        md(6'b011000, -32'sd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 34, seen);
        md(6'b011010, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, seen);
        drain();
`else
        ctrl_q.push_back(4'b1111);
        issue(3'b010, 6'b011010, -32'sd7, 32'd2, seen);
        @(negedge clk);
        chk("nosigned_div_busy", {63'd0, Busy}, 64'd0);
        ctrl_q.push_back(4'b1111);
        issue(3'b010, 6'b011000, -32'sd3, 32'd4, seen);
        @(negedge clk);
        chk("nosigned_mul_busy", {63'd0, Busy}, 64'd0);
        drain();
`endif

        ctrl_q.push_back(4'b1111);
        issue(3'b010, 6'b011001, 32'd3, 32'd4, seen);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hi", {32'd0, Hi}, 64'd0);
        chk("abort_lo", {32'd0, Lo}, 64'd0);
        chk("abort_aluctrl", {60'd0, ALUCtrl}, 64'hF);
        chk("abort_mddone", {63'd0, MdDone}, 64'd0);
        chk("abort_ready", {63'd0, Ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ctrl(3'b000, 6'b000000, 4'b0010);
        repeat (40) @(negedge clk);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Parametrised, registered ALU control for the MIPS datapath.
- Decodes ALUOp/Funct into a 4-bit ALU operation code, one cycle after acceptance.
- Adds an iterative unsigned multiply/divide sequencer that owns the HI/LO registers.
- Sits between the main control unit and the ALU/HI-LO writeback mux. Busy stalls the pipeline front end while a multiply or divide runs.

Parameters:
WIDTH, 32, operand and HI/LO width; must be ≥ 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Valid  in  1  request present this cycle
Ready  out  1  = ~Busy; request accepted when Valid && Ready
ALUOp  in  3  class code from main control
Funct  in  6  instruction funct field
A  in  WIDTH  rs operand (used by mul/div only)
B  in  WIDTH  rt operand (used by mul/div only)
ALUCtrl  out  4  registered ALU operation code
CtrlValid  out  1  ALUCtrl updated this cycle
Busy  out  1  mul/div in progress
MdDone  out  1  one-cycle pulse, HI/LO just written
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - ALUCtrl=4'b1111 (NOP); CtrlValid=0, Busy=0, MdDone=0; Hi=0, Lo=0.
  - Sequencer goes to IDLE and the counter clears.
  - Asserting reset mid-operation aborts the operation and leaves no partial HI/LO update.
- Decode, registered, latency 1. On the accepting edge, ALUCtrl loads and CtrlValid=1 next cycle; CtrlValid=0 in cycles with no accept.
- ALUOp map:
  - 000 lw/sw→0010; 001 beq→0110; 011 addi→0010; 100 slti→0111; 101 bne→1110; 110 ori→0001; 111 andi→0000.
  - 010 R-type, by Funct: 100100 AND→0000; 100101 OR→0001; 100000 ADD→0010; 100010 SUB→0110; 101010 SLT→0111; 100111 NOR→1100; 010000 MFHI→1000; 010010 MFLO→1001; 011001 MULTU→1111 plus start MUL; 011011 DIVU→1111 plus start DIV.
  - Any other Funct→1111. No latched/held value for unmapped codes.
- Sequencer states: IDLE→MUL|DIV on accepted start; MUL/DIV→FIN after the count expires; FIN→IDLE.
- MUL: shift-add, one bit per cycle, for WIDTH cycles. The 2·WIDTH product is split {Hi,Lo}.
- DIV: restoring, one quotient bit per cycle, for WIDTH cycles. Lo=quotient, Hi=remainder.
- Divide by zero (B==0 on DIVU accept): skip iteration and go straight to FIN. Hi=A, Lo=all ones.
- Busy=1 from the cycle after the accept through the FIN cycle. That is WIDTH+1 cycles normally, 1 cycle for divide by zero.
- Hi/Lo are written on the FIN→IDLE edge. MdDone=1 in the first cycle after that edge.
- Operands are captured at accept; A/B changes during Busy have no effect.
- Valid while Busy: not accepted (Ready=0); ALUCtrl holds its value.
- Back-to-back requests are allowed:
  - Non-mul/div: accept every cycle.
  - Mul/div: a new request is accepted in the MdDone cycle.
- MFHI/MFLO issued in the MdDone cycle see the new Hi/Lo.

Optional Feature:
Macro SIGNED_MD_EN.
- Defined: Funct 011000 MULT and 011010 DIV also start the sequencer.
  - Operands are converted to magnitudes at accept and an extra FIX state before FIN applies sign correction. Busy is 1 cycle longer.
  - DIV remainder takes the sign of A.
  - Signed divide by zero follows the same rule as unsigned (Hi=A, Lo=all ones).
- Undefined: 011000/011010 decode to 1111 with no start, and the FIX state is absent.

Test Plan:
- Reset then ALUOp=010, Funct=100010 with Valid → next cycle ALUCtrl=0110, CtrlValid=1. Funct=111111 → ALUCtrl=1111.
- MULTU A=32'hFFFFFFFF, B=2 → Busy high for 33 cycles, Ready=0. MdDone pulse; Hi=1, Lo=32'hFFFFFFFE.
- DIVU A=100, B=7 → after completion Lo=14, Hi=2. A/B toggled during Busy → no effect.
- DIVU A=5, B=0 → Busy for exactly 1 cycle; Hi=5, Lo=32'hFFFFFFFF.
- Start MULTU 3×4, drop rst_n at cycle 10 → Busy=0, Hi=Lo=0, ALUCtrl=1111 immediately. After release, ALUOp=000 → 0010.
- SIGNED_MD_EN: DIV A=-7, B=2 → Lo=-3, Hi=-1, Busy=34 cycles. Without the macro: same request → no Busy, ALUCtrl=1111.
